dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 128-word data SRAM between two requesters: requester 0 is the single-cycle core's load/store port, and requester 1 is the program/data loader or a DMA engine. It issues at most one SRAM access per cycle and drives the active-low SRAM controls (CEN/WEN/OEN). It also tracks in-flight reads through a latency pipeline so that each read response is returned to the requester that issued it. A requester that is not granted is stalled; for the core, `r0_gnt` low is the pipeline-freeze condition.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between the core (requester 0)
// and a loader/DMA engine (requester 1). Tracks in-flight reads so each response is
// returned to the requester that issued it.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    // Pointer to the most recently granted requester; 1 after reset so r0 wins first.
    logic last_gnt_q, last_gnt_d;

    // Read-return pipeline: one {valid, id} entry per cycle of SRAM read latency.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;

    logic rd_push;
    logic rd_id;

    // Arbitration: uncontested requests win immediately, contention alternates.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (r0_req && r1_req) begin
                r0_gnt = last_gnt_q;
                r1_gnt = ~last_gnt_q;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    // SRAM command mux, read-pipeline push and pointer next state.
    always_comb begin
        CEN        = 1'b1;
        WEN        = 1'b1;
        A          = '0;
        D          = '0;
        rd_push    = 1'b0;
        rd_id      = 1'b0;
        last_gnt_d = last_gnt_q;
        if (r0_gnt) begin
            CEN        = 1'b0;
            WEN        = ~r0_we;
            A          = r0_addr;
            D          = r0_wdata;
            rd_push    = ~r0_we;
            rd_id      = 1'b0;
            last_gnt_d = 1'b0;
        end else if (r1_gnt) begin
            CEN        = 1'b0;
            WEN        = ~r1_we;
            A          = r1_addr;
            D          = r1_wdata;
            rd_push    = ~r1_we;
            rd_id      = 1'b1;
            last_gnt_d = 1'b1;
        end
    end

    // Shift the read pipeline by one stage per cycle.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_id_d     = '0;
        pipe_vld_d[0] = rd_push;
        pipe_id_d[0]  = rd_id;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    // State registers; reset discards any in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    // Output enable covers the whole window from read grant to data return.
    always_comb begin
        OEN = ~((|pipe_vld_q) | rd_push);
    end

    // Route returning read data to the requester that issued it.
    always_comb begin
        r0_rvalid = pipe_vld_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1];
        r1_rvalid = pipe_vld_q[RD_LAT-1] & pipe_id_q[RD_LAT-1];
        r0_rdata  = r0_rvalid ? Q : '0;
        r1_rdata  = r1_rvalid ? Q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (read latency 1, 2, 3) share one stimulus
// stream, each with its own SRAM model; a behavioural model checks every cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [6:0]  r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_wdata = '0, r1_wdata = '0;

    logic        gnt0 [3], gnt1 [3], rv0 [3], rv1 [3], cen [3], wen [3], oen [3];
    logic [6:0]  a_o [3];
    logic [31:0] d_o [3], rd0 [3], rd1 [3], q [3];

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [6:0] a);
        return {16'hC0DE, 9'b0, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        logic [31:0] mem [128];
        bit   [127:0] seen;
        logic [31:0] qp [L];

        dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .RD_LAT(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
            .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
            .r0_gnt(gnt0[g]), .r1_gnt(gnt1[g]),
            .r0_rvalid(rv0[g]), .r1_rvalid(rv1[g]),
            .r0_rdata(rd0[g]), .r1_rdata(rd1[g]),
            .CEN(cen[g]), .WEN(wen[g]), .OEN(oen[g]), .A(a_o[g]), .D(d_o[g]), .Q(q[g])
        );

        // SRAM model: samples at the edge, read data appears L edges later.
        always @(posedge clk) begin
            if (!cen[g]) begin
                if (!wen[g]) begin
                    mem[a_o[g]]  <= d_o[g];
                    seen[a_o[g]] <= 1'b1;
                end else begin
                    qp[0] <= seen[a_o[g]] ? mem[a_o[g]] : init_val(a_o[g]);
                end
            end
            for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
        end
        assign q[g] = qp[L-1];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Behavioural model state: grant pointer, memory contents, and reads due per cycle.
    bit          m_last = 1'b1;
    bit   [31:0] mm [128];
    bit          mw [128];
    bit          sv [3][8];
    bit          sid [3][8];
    logic [31:0] sdat [3][8];
    bit          have_rd [3];
    int          last_rd [3];

    bit          eg0, eg1, erd, ecen, ewen, erv0, erv1, eoen, eid;
    logic [6:0]  ea;
    logic [31:0] ed, erd0, erd1, rdv;
    int          slot, lat;

    always @(negedge clk) begin
        if (run) begin
            eg0  = rst_n && r0_req && (!r1_req || m_last);
            eg1  = rst_n && r1_req && (!r0_req || !m_last);
            erd  = (eg0 && !r0_we) || (eg1 && !r1_we);
            eid  = eg1;
            ecen = !(eg0 || eg1);
            ewen = eg0 ? !r0_we : (eg1 ? !r1_we : 1'b1);
            ea   = eg0 ? r0_addr : (eg1 ? r1_addr : 7'd0);
            ed   = eg0 ? r0_wdata : (eg1 ? r1_wdata : 32'd0);
            rdv  = mw[ea] ? mm[ea] : init_val(ea);
            slot = cyc_n % 8;
            for (int k = 0; k < 3; k++) begin
                lat  = k + 1;
                erv0 = rst_n && sv[k][slot] && !sid[k][slot];
                erv1 = rst_n && sv[k][slot] && sid[k][slot];
                erd0 = erv0 ? sdat[k][slot] : 32'd0;
                erd1 = erv1 ? sdat[k][slot] : 32'd0;
                eoen = !(rst_n && (erd || (have_rd[k] && cyc_n <= last_rd[k] + lat)));
                chk1($sformatf("d%0d r0_gnt", k), gnt0[k], eg0);
                chk1($sformatf("d%0d r1_gnt", k), gnt1[k], eg1);
                chk1($sformatf("d%0d CEN", k), cen[k], ecen);
                chk1($sformatf("d%0d WEN", k), wen[k], ewen);
                chk1($sformatf("d%0d OEN", k), oen[k], eoen);
                chk32($sformatf("d%0d A", k), {25'd0, a_o[k]}, {25'd0, ea});
                chk32($sformatf("d%0d D", k), d_o[k], ed);
                chk1($sformatf("d%0d r0_rvalid", k), rv0[k], erv0);
                chk1($sformatf("d%0d r1_rvalid", k), rv1[k], erv1);
                chk32($sformatf("d%0d r0_rdata", k), rd0[k], erd0);
                chk32($sformatf("d%0d r1_rdata", k), rd1[k], erd1);
                sv[k][slot] = 1'b0;
                if (!rst_n) begin
                    for (int s = 0; s < 8; s++) sv[k][s] = 1'b0;
                    have_rd[k] = 1'b0;
                end else if (erd) begin
                    sv[k][(cyc_n + lat) % 8]   = 1'b1;
                    sid[k][(cyc_n + lat) % 8]  = eid;
                    sdat[k][(cyc_n + lat) % 8] = rdv;
                    have_rd[k] = 1'b1;
                    last_rd[k] = cyc_n;
                end
            end
            if (!ecen && !ewen) begin
                mm[ea] = ed;
                mw[ea] = 1'b1;
            end
            if (!rst_n) m_last = 1'b1;
            else if (eg0) m_last = 1'b0;
            else if (eg1) m_last = 1'b1;
            cyc_n++;
        end
    end

    task automatic step(input bit rst, input bit q0, input bit w0, input int a0,
                        input logic [31:0] d0, input bit q1, input bit w1, input int a1,
                        input logic [31:0] d1);
        @(posedge clk);
        #1;
        rst_n    = rst;
        r0_req   = q0;
        r0_we    = w0;
        r0_addr  = a0[6:0];
        r0_wdata = d0;
        r1_req   = q1;
        r1_we    = w1;
        r1_addr  = a1[6:0];
        r1_wdata = d1;
        run      = 1'b1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        // Reset with both requesting: nothing may be granted.
        step(1'b0, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 2, 0);
        step(1'b0, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 2, 0);
        settle();
        chk1("rst r0_gnt", gnt0[0], 1'b0);
        chk1("rst r1_gnt", gnt1[0], 1'b0);
        chk1("rst CEN", cen[0], 1'b1);
        chk1("rst OEN", oen[0], 1'b1);
        chk32("rst A", {25'd0, a_o[0]}, 32'd0);
        idle();

        // Uncontested write then read-back of address 5.
        step(1'b1, 1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0);
        settle();
        chk1("wr gnt", gnt0[0], 1'b1);
        chk1("wr WEN", wen[0], 1'b0);
        chk32("wr A", {25'd0, a_o[0]}, 32'd5);
        step(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 0);
        settle();
        chk1("rd gnt", gnt0[0], 1'b1);
        chk1("rd OEN", oen[0], 1'b0);
        idle();
        settle();
        chk1("rd r0_rvalid", rv0[0], 1'b1);
        chk32("rd r0_rdata", rd0[0], 32'hDEADBEEF);
        chk1("rd r1_rvalid", rv1[0], 1'b0);
        repeat (3) idle();

        // Reset pulse, then continuous contention must alternate starting with r0.
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 10 + (i + 1) / 2, 0, 1'b1, 1'b0, 20 + i / 2, 0);
            settle();
            chk1("cont r0_gnt", gnt0[0], (i % 2) == 0);
            chk1("cont r1_gnt", gnt1[0], (i % 2) == 1);
        end

        // Withdrawal: r1 loses, then drops its request; pointer stays on r0.
        step(1'b1, 1'b1, 1'b1, 30, 32'h12345678, 1'b1, 1'b0, 40, 0);
        settle();
        chk32("wd A", {25'd0, a_o[0]}, 32'd30);
        chk1("wd r1_gnt", gnt1[0], 1'b0);
        idle();
        settle();
        chk1("wd CEN", cen[0], 1'b1);
        step(1'b1, 1'b1, 1'b0, 30, 0, 1'b1, 1'b0, 40, 0);
        settle();
        chk1("wd next r1_gnt", gnt1[0], 1'b1);
        step(1'b1, 1'b1, 1'b0, 30, 0, 1'b0, 1'b0, 0, 0);
        repeat (4) idle();

        // Back-to-back r1 reads of 127 and 0; check the latency-3 instance.
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 127, 0);
        settle();
        chk1("lat3 OEN t", oen[2], 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        settle();
        chk1("lat3 OEN t+1", oen[2], 1'b0);
        for (int j = 2; j < 6; j++) begin
            idle();
            settle();
            chk1("lat3 r1_rvalid", rv1[2], (j == 3) || (j == 4));
            chk1("lat3 OEN", oen[2], j == 5);
            if (j == 3) chk32("lat3 rdata 127", rd1[2], 32'hC0DE007F);
            if (j == 4) chk32("lat3 rdata 0", rd1[2], 32'hC0DE0000);
        end

        // Write, then read, then reset mid-read: the read never returns, the write sticks.
        step(1'b1, 1'b1, 1'b1, 50, 32'hCAFEF00D, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        for (int j = 2; j < 5; j++) begin
            idle();
            settle();
            chk1("rstrd lat2 r0_rvalid", rv0[1], 1'b0);
            chk1("rstrd lat3 r0_rvalid", rv0[2], 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 50, 0, 1'b0, 1'b0, 0, 0);
        idle();
        settle();
        chk1("post-rst r0_rvalid", rv0[0], 1'b1);
        chk32("post-rst r0_rdata", rd0[0], 32'hCAFEF00D);
        repeat (4) idle();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
